// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N_REQ byte clients.
// Per-byte arbitration with optional packet lock; tx_data held for the whole frame.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LOCK_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_idle,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  // state     | meaning
  // ARB       | pick a winner when serializer idle; accept its byte
  // START     | one-cycle tx_start pulse
  // WAIT_BUSY | wait for serializer to leave idle
  // WAIT_IDLE | frame on the line; wait for idle, then release or keep lock
  typedef enum logic [1:0] {ARB, START, WAIT_BUSY, WAIT_IDLE} state_t;

  localparam int PW = $clog2(N_REQ);

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, owner, win_idx;
  logic            win_found, lock, last_flag, accept, done;

  always_comb begin : pick
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    // search starts one past the pointer so the last owner gets lowest priority
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!win_found && req_valid[idx] && (!lock || PW'(idx) == owner)) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      ARB: begin
        if (tx_idle && win_found) begin
          accept             = 1'b1;
          req_ready[win_idx] = 1'b1;
          state_nxt          = START;
        end
      end
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!tx_idle) state_nxt = WAIT_IDLE;
      WAIT_IDLE: begin
        if (tx_idle) begin
          done      = 1'b1;
          state_nxt = ARB;
        end
      end
      default:   state_nxt = ARB;
    endcase
  end

  assign tx_start = (state == START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= PW'(N_REQ - 1);
      owner     <= '0;
      lock      <= 1'b0;
      last_flag <= 1'b0;
      tx_data   <= 8'h00;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_data   <= req_data[8*win_idx +: 8];
        grant     <= N_REQ'(1) << win_idx;
        busy      <= 1'b1;
        owner     <= win_idx;
        last_flag <= req_last[win_idx];
      end
      if (done) begin
        busy <= 1'b0;
        if (LOCK_EN == 0 || last_flag) begin
          lock  <= 1'b0;
          grant <= '0;
          ptr   <= owner;
        end else begin
          lock <= 1'b1;
        end
      end
    end
  end

endmodule
